seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 170 +++++++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu: operands and command in, status and result out.
interface seq_alu_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          start;
    logic [2:0]    alu_cmd;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  rslt;
    logic          zero;
    logic          carry;

    modport master (
        output start, alu_cmd, rd_a, rd_b, rd_addr_a, rd_addr_b,
        input  busy, done, rslt, zero, carry
    );

    modport slave (
        input  start, alu_cmd, rd_a, rd_b, rd_addr_a, rd_addr_b,
        output busy, done, rslt, zero, carry
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/AND/XOR/CMP/MOVE, iterative rotate and shift-add multiply.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold last result
// RUN    | rotate/multiply iterating, one step per cycle; busy=1
// DONE   | one-cycle done pulse; a new start is accepted here too
module seq_alu #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input logic        clk_i,
    input logic        rst_i,
    seq_alu_if.slave   bus
);
    localparam int LW = $clog2(W);
    localparam int CW = LW + 1;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_AND  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_CMP  = 3'b011;
    localparam logic [2:0] CMD_MOVE = 3'b100;
    localparam logic [2:0] CMD_ROTL = 3'b101;
    localparam logic [2:0] CMD_ROTR = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [2*W-1:0]  a_q, a_d;       // rotate value (low W bits) or shifting multiplicand
    logic [W-1:0]    b_q, b_d;       // multiplier, consumed LSB first
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;   // remaining iterations; last step when it reads 1
    logic [W-1:0]    rslt_q, rslt_d;
    logic            zero_q, zero_d;
    logic            carry_q, carry_d;

    logic            accept;
    logic [LW-1:0]   k;
    logic [W:0]      sum;
    logic [W:0]      diff;
    logic [2*W-1:0]  acc_step;
    logic [W-1:0]    rot_l;
    logic [W-1:0]    rot_r;
    logic [W-1:0]    res;
    logic            res_c;
    logic            load;

    assign accept   = bus.start && (state_q != S_RUN);
    assign k        = bus.rd_b[LW-1:0];
    assign sum      = {1'b0, bus.rd_a} + {1'b0, bus.rd_b};
    assign diff     = {1'b0, bus.rd_a} - {1'b0, bus.rd_b};
    assign acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
    assign rot_l    = {a_q[W-2:0], a_q[W-1]};
    assign rot_r    = {a_q[0], a_q[W-1:1]};

    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.rslt  = rslt_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;

    // Next-state, operand capture, iteration step and result load.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rslt_d  = rslt_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        res     = '0;
        res_c   = 1'b0;
        load    = 1'b0;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cmd_q == CMD_ROTL || cmd_q == CMD_ROTR) begin
                    res = (cmd_q == CMD_ROTL) ? rot_l : rot_r;
                    a_d = {{W{1'b0}}, res};
                end else begin
                    acc_d = acc_step;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    res   = acc_step[W-1:0];
                    res_c = |acc_step[2*W-1:W];
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    cmd_d   = bus.alu_cmd;
                    state_d = S_DONE;
                    load    = 1'b1;
                    case (bus.alu_cmd)
                        CMD_ADD: begin
                            res   = sum[W-1:0];
                            res_c = sum[W];
                        end
                        CMD_AND:  res = bus.rd_a & bus.rd_b;
                        CMD_XOR:  res = (bus.rd_addr_a == bus.rd_addr_b) ? W'(^bus.rd_a)
                                                                        : (bus.rd_a ^ bus.rd_b);
                        CMD_CMP: begin
                            res   = diff[W-1:0];
                            res_c = diff[W];
                        end
                        CMD_MOVE: res = bus.rd_b;
                        CMD_ROTL, CMD_ROTR: begin
                            if (k == '0) begin
                                res = bus.rd_a;
                            end else begin
                                load    = 1'b0;
                                state_d = S_RUN;
                                a_d     = {{W{1'b0}}, bus.rd_a};
                                cnt_d   = CW'(k);
                            end
                        end
                        default: begin
                            load    = 1'b0;
                            state_d = S_RUN;
                            a_d     = {{W{1'b0}}, bus.rd_a};
                            b_d     = bus.rd_b;
                            acc_d   = '0;
                            cnt_d   = CW'(W);
                        end
                    endcase
                end
            end
        endcase

        if (load) begin
            rslt_d  = res;
            zero_d  = (res == '0);
            carry_d = res_c;
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            rslt_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rslt_q  <= rslt_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus hand-written multi-cycle sequences.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_alu_if #(.W(8),  .AW(3)) bus8 ();
    seq_alu_if #(.W(16), .AW(3)) bus16 ();

    seq_alu #(.W(8),  .AW(3)) dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
    seq_alu #(.W(16), .AW(3)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] aa;
        logic [2:0] ab;
        logic [7:0] r;
        logic       z;
        logic       c;
        int         lat;
    } vec_t;

    vec_t vecs[18];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic [2:0] cmd, logic [7:0] a, logic [7:0] b,
                                logic [2:0] aa, logic [2:0] ab, logic [7:0] r,
                                logic z, logic c, int lat);
        vec_t v;
        v.name = nm; v.cmd = cmd; v.a = a; v.b = b; v.aa = aa; v.ab = ab;
        v.r = r; v.z = z; v.c = c; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive8(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] aa, input logic [2:0] ab);
        bus8.alu_cmd   = cmd;
        bus8.rd_a      = a;
        bus8.rd_b      = b;
        bus8.rd_addr_a = aa;
        bus8.rd_addr_b = ab;
    endtask

    task automatic do_op(input vec_t v);
        int         cyc;
        int         bcyc;
        logic [7:0] prev;
        logic       held;
        prev = bus8.rslt;
        held = 1'b1;
        @(negedge clk);
        drive8(v.cmd, v.a, v.b, v.aa, v.ab);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        cyc  = 1;
        bcyc = 0;
        while (!bus8.done && cyc < 40) begin
            if (bus8.busy) bcyc++;
            if (bus8.rslt !== prev) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " latency"}, cyc, v.lat);
        chk({v.name, " busy_cycles"}, bcyc, v.lat - 1);
        chk({v.name, " rslt_held"}, {31'd0, held}, 32'd1);
        chk({v.name, " rslt"}, {24'd0, bus8.rslt}, {24'd0, v.r});
        chk({v.name, " zero"}, {31'd0, bus8.zero}, {31'd0, v.z});
        chk({v.name, " carry"}, {31'd0, bus8.carry}, {31'd0, v.c});
        @(negedge clk);
        chk({v.name, " done_one_cycle"}, {31'd0, bus8.done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;

        vecs[0]  = mk("add_f0_20",   3'b000, 8'hF0, 8'h20, 3'd0, 3'd1, 8'h10, 1'b0, 1'b1, 1);
        vecs[1]  = mk("add_01_02",   3'b000, 8'h01, 8'h02, 3'd0, 3'd1, 8'h03, 1'b0, 1'b0, 1);
        vecs[2]  = mk("add_ff_01",   3'b000, 8'hFF, 8'h01, 3'd0, 3'd1, 8'h00, 1'b1, 1'b1, 1);
        vecs[3]  = mk("and_f0_0f",   3'b001, 8'hF0, 8'h0F, 3'd0, 3'd1, 8'h00, 1'b1, 1'b0, 1);
        vecs[4]  = mk("and_3c_f5",   3'b001, 8'h3C, 8'hF5, 3'd0, 3'd1, 8'h34, 1'b0, 1'b0, 1);
        vecs[5]  = mk("xor_par_07",  3'b010, 8'h07, 8'hAA, 3'd3, 3'd3, 8'h01, 1'b0, 1'b0, 1);
        vecs[6]  = mk("xor_par_03",  3'b010, 8'h03, 8'h55, 3'd5, 3'd5, 8'h00, 1'b1, 1'b0, 1);
        vecs[7]  = mk("xor_0f_0f",   3'b010, 8'h0F, 8'h0F, 3'd2, 3'd3, 8'h00, 1'b1, 1'b0, 1);
        vecs[8]  = mk("xor_0f_f0",   3'b010, 8'h0F, 8'hF0, 3'd2, 3'd3, 8'hFF, 1'b0, 1'b0, 1);
        vecs[9]  = mk("cmp_05_05",   3'b011, 8'h05, 8'h05, 3'd0, 3'd1, 8'h00, 1'b1, 1'b0, 1);
        vecs[10] = mk("cmp_03_05",   3'b011, 8'h03, 8'h05, 3'd0, 3'd1, 8'hFE, 1'b0, 1'b1, 1);
        vecs[11] = mk("move_34",     3'b100, 8'h12, 8'h34, 3'd0, 3'd1, 8'h34, 1'b0, 1'b0, 1);
        vecs[12] = mk("rotl_81_k3",  3'b101, 8'h81, 8'h0B, 3'd0, 3'd1, 8'h0C, 1'b0, 1'b0, 4);
        vecs[13] = mk("rotr_81_k0",  3'b110, 8'h81, 8'h08, 3'd0, 3'd1, 8'h81, 1'b0, 1'b0, 1);
        vecs[14] = mk("rotr_81_k1",  3'b110, 8'h81, 8'h01, 3'd0, 3'd1, 8'hC0, 1'b0, 1'b0, 2);
        vecs[15] = mk("rotl_01_k7",  3'b101, 8'h01, 8'h07, 3'd0, 3'd1, 8'h80, 1'b0, 1'b0, 8);
        vecs[16] = mk("mul_10_11",   3'b111, 8'h10, 8'h11, 3'd0, 3'd1, 8'h10, 1'b0, 1'b1, 9);
        vecs[17] = mk("mul_0f_0f",   3'b111, 8'h0F, 8'h0F, 3'd0, 3'd1, 8'hE1, 1'b0, 1'b0, 9);

        bus8.start = 1'b0;
        drive8(3'b000, 8'h00, 8'h00, 3'd0, 3'd0);
        bus16.start     = 1'b0;
        bus16.alu_cmd   = 3'b000;
        bus16.rd_a      = 16'h0000;
        bus16.rd_b      = 16'h0000;
        bus16.rd_addr_a = 3'd0;
        bus16.rd_addr_b = 3'd1;

        // reset values
        repeat (2) @(negedge clk);
        chk("reset busy",  {31'd0, bus8.busy},  32'd0);
        chk("reset done",  {31'd0, bus8.done},  32'd0);
        chk("reset rslt",  {24'd0, bus8.rslt},  32'd0);
        chk("reset zero",  {31'd0, bus8.zero},  32'd0);
        chk("reset carry", {31'd0, bus8.carry}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) do_op(vecs[i]);

        // start pulsed while rotating is ignored
        @(negedge clk);
        drive8(3'b101, 8'h81, 8'h0B, 3'd0, 3'd1);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        cyc = 1;
        chk("ign busy", {31'd0, bus8.busy}, 32'd1);
        @(negedge clk);
        cyc++;
        drive8(3'b000, 8'hFF, 8'hFF, 3'd0, 3'd1);
        bus8.start = 1'b1;
        @(negedge clk);
        cyc++;
        bus8.start = 1'b0;
        while (!bus8.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign latency", cyc, 4);
        chk("ign rslt",  {24'd0, bus8.rslt},  32'h0C);
        chk("ign carry", {31'd0, bus8.carry}, 32'd0);
        @(negedge clk);

        // back-to-back: start held through DONE
        drive8(3'b000, 8'h01, 8'h01, 3'd0, 3'd1);
        bus8.start = 1'b1;
        @(negedge clk);
        chk("b2b done1", {31'd0, bus8.done}, 32'd1);
        chk("b2b rslt1", {24'd0, bus8.rslt}, 32'h02);
        drive8(3'b100, 8'h00, 8'h5A, 3'd0, 3'd1);
        @(negedge clk);
        chk("b2b done2", {31'd0, bus8.done}, 32'd1);
        chk("b2b rslt2", {24'd0, bus8.rslt}, 32'h5A);
        bus8.start = 1'b0;
        @(negedge clk);
        chk("b2b done3", {31'd0, bus8.done}, 32'd0);
        chk("b2b hold",  {24'd0, bus8.rslt}, 32'h5A);

        // reset in the middle of a multiply
        drive8(3'b111, 8'h10, 8'h11, 3'd0, 3'd1);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid busy_pre", {31'd0, bus8.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid busy",  {31'd0, bus8.busy},  32'd0);
        chk("mid done",  {31'd0, bus8.done},  32'd0);
        chk("mid rslt",  {24'd0, bus8.rslt},  32'd0);
        chk("mid zero",  {31'd0, bus8.zero},  32'd0);
        chk("mid carry", {31'd0, bus8.carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) pulses++;
        end
        chk("mid no_done", pulses, 0);
        do_op(mk("post_rst_add", 3'b000, 8'h01, 8'h01, 3'd0, 3'd1, 8'h02, 1'b0, 1'b0, 1));

        // W=16 multiply with nonzero high half and zero low half
        @(negedge clk);
        bus16.alu_cmd = 3'b111;
        bus16.rd_a    = 16'h0100;
        bus16.rd_b    = 16'h0100;
        bus16.start   = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        cyc = 1;
        while (!bus16.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("mul16 latency", cyc, 17);
        chk("mul16 rslt",  {16'd0, bus16.rslt}, 32'h0000);
        chk("mul16 zero",  {31'd0, bus16.zero},  32'd1);
        chk("mul16 carry", {31'd0, bus16.carry}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
